load_unit: RTL
==============

# load_unit

Sequential load path of the datapath, the read-side counterpart of the store merge logic. It takes a load request (address plus RV64I load type), fetches the aligned doubleword from data memory over a request/valid handshake, then extracts the addressed byte, halfword, word or doubleword. It sign- or zero-extends the result to 64 bits and presents it to register writeback with a one-cycle `done` pulse. The unit sits between the control FSM and the data memory port, and reports misaligned, illegal-type and timeout errors.

## Interface
- `TIMEOUT`, 255: max cycles waiting for `mem_rvalid` before aborting with error; counter width `$clog2(TIMEOUT+1)`.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request pulse; sampled only in IDLE.
- `funct3` in 3: load type. 0 LB, 1 LH, 2 LW, 3 LD, 4 LBU, 5 LHU, 6 LWU, 7 illegal.
- `addr` in 64: byte address of the load.
- `mem_rdata` in 64: doubleword returned by memory.
- `mem_rvalid` in 1: `mem_rdata` valid this cycle.
- `mem_req` out 1: read request; held high until `mem_rvalid` or timeout.
- `mem_addr` out 64: `{addr[63:3], 3'b000}` of the latched request.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`. High for misaligned, illegal or timeout.
- `result` out 64: extended load data. Holds its value until the next `done`.

## Operation
- States are IDLE, WAIT, DONE.
- **IDLE**, `start`=1:
  - Latch `funct3`, `addr[2:0]` and `addr[63:3]`.
  - Illegal type or misaligned: go to DONE with `err`=1 and `result`=0. No `mem_req` is issued.
  - Otherwise go to WAIT.
- **Misalignment rules**:
  - LH/LHU: `addr[0]`≠0.
  - LW/LWU: `addr[1:0]`≠0.
  - LD: `addr[2:0]`≠0.
  - LB/LBU: never misaligned.
- **WAIT**:
  - `mem_req`=1 and `mem_addr` is stable.
  - On `mem_rvalid`=1: `result` ← extract(`mem_rdata` >> 8·offset, type), go to DONE.
  - If the timeout counter reaches `TIMEOUT` without `mem_rvalid`: `err`=1, `result`=0, go to DONE.
- **DONE**: `done`=1 for exactly one cycle, then go to IDLE.
- **Extraction**:
  - LB/LH/LW take bits [7:0]/[15:0]/[31:0] of the shifted word and sign-extend from bit 7/15/31.
  - LBU/LHU/LWU zero-extend.
  - LD takes all 64 bits.
- `start` while `busy`: ignored, no queueing.
- `mem_rvalid` outside WAIT: ignored.
- `mem_rvalid` in the same cycle the timeout is reached: the data wins, `err`=0.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `busy`=0, `done`=0, `err`=0, `result`=0. State goes to IDLE and the timeout counter clears.
- `reset_n` asserted mid-operation: outputs drop immediately, asynchronously. Any later `mem_rvalid` is ignored.
- Cycle 0: `start` sampled in IDLE.
- Cycle 1: `mem_req` high (WAIT).
- `mem_rvalid` at cycle k≥1: `result`/`done`/`err` registered and visible in cycle k+1. `mem_req` is low in cycle k+1.
- Minimum latency from `start` to `done` is 2 cycles.
- Error path (misaligned/illegal): `done` in cycle 1, `mem_req` never high.
- Timeout: `done`/`err` one cycle after the counter hits `TIMEOUT`, i.e. cycle `TIMEOUT`+2 when no `mem_rvalid` arrives.
- Back-to-back: `start` is accepted again in the cycle after `done`.

## Structure
- Shared package `load_pkg` holds:
  - enum `load_type_e` (the eight `funct3` codes above);
  - enum `load_state_e` {IDLE, WAIT, DONE};
  - localparam `DWORD_BYTES` = 8.
- Sub-module `load_align`, purely combinational: inputs `data[63:0]`, `offset[2:0]`, `load_type_e`; output is the extended 64-bit value.
- `load_unit` holds the FSM, the latched request, the timeout counter and the output registers.

## Test plan
- `mem_rdata`=0xF0E1D2C3B4A59687 is used throughout.
- LB, `addr`=0x1000, `mem_rvalid` 3 cycles after `start`:
  - `mem_addr`=0x1000;
  - `result`=0xFFFFFFFFFFFFFF87, `err`=0;
  - `done` in cycle 4.
- LBU `addr`=0x1000 gives 0x0000000000000087. LHU `addr`=0x1002 gives 0x000000000000B4A5. LH `addr`=0x1002 gives 0xFFFFFFFFFFFFB4A5.
- LW `addr`=0x1004 gives 0xFFFFFFFFF0E1D2C3, with `mem_addr`=0x1000. LWU gives 0x00000000F0E1D2C3. LD `addr`=0x1000 gives 0xF0E1D2C3B4A59687.
- Error cases:
  - LW at `addr`=0x1002: `done`+`err` in cycle 1, `result`=0, `mem_req` stays 0.
  - `funct3`=7: same response.
- Timeout with `TIMEOUT`=4 and no `mem_rvalid`: `done`+`err`=1 at cycle 6, `mem_req` low afterwards. A second `start` in the next cycle proceeds normally.
- `reset_n` pulled low in WAIT: `mem_req`/`busy` drop immediately. A late `mem_rvalid` produces no `done`. A fresh `start` after release completes normally.

Source files
------------

// File: rtl/load_pkg.sv
// Shared types for the load path: RV64I load encodings, FSM states and alignment helpers.
package load_pkg;

    localparam int DWORD_BYTES = 8;
    localparam int OFF_W       = $clog2(DWORD_BYTES);

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LD  = 3'd3,
        LBU = 3'd4,
        LHU = 3'd5,
        LWU = 3'd6,
        LIL = 3'd7
    } load_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } load_state_e;

    // True when the request can never reach memory: illegal code or natural-alignment violation.
    function automatic logic bad_req(input load_type_e t, input logic [OFF_W-1:0] off);
        case (t)
            LH, LHU: bad_req = off[0];
            LW, LWU: bad_req = |off[1:0];
            LD:      bad_req = |off;
            LIL:     bad_req = 1'b1;
            default: bad_req = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half/word/dword out of a doubleword and sign- or zero-extends it.
module load_align
    import load_pkg::*;
(
    input  logic [63:0]      data,
    input  logic [OFF_W-1:0] offset,
    input  load_type_e       ltype,
    output logic [63:0]      value
);

    logic [63:0] sh;

    always_comb begin
        sh = data >> {offset, 3'b000};
        case (ltype)
            LB:      value = {{56{sh[7]}},  sh[7:0]};
            LH:      value = {{48{sh[15]}}, sh[15:0]};
            LW:      value = {{32{sh[31]}}, sh[31:0]};
            LBU:     value = {56'd0, sh[7:0]};
            LHU:     value = {48'd0, sh[15:0]};
            LWU:     value = {32'd0, sh[31:0]};
            default: value = sh;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load FSM: issues an aligned doubleword read, extracts/extends the addressed data,
// and reports misaligned, illegal-type and timeout errors with a one-cycle done pulse.
module load_unit
    import load_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [63:0] result
);

    localparam int CW = $clog2(TIMEOUT + 1);

    load_state_e      state;
    load_type_e       ltype;
    logic [OFF_W-1:0] off;
    logic [CW-1:0]    cnt;
    logic [63:0]      ext;

    load_align u_align (
        .data   (mem_rdata),
        .offset (off),
        .ltype  (ltype),
        .value  (ext)
    );

    // Status outputs decode straight from state so async reset drops them at once.
    assign mem_req = (state == WAIT);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ltype    <= LB;
            off      <= '0;
            mem_addr <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ltype    <= load_type_e'(funct3);
                    off      <= addr[OFF_W-1:0];
                    mem_addr <= {addr[63:OFF_W], {OFF_W{1'b0}}};
                    cnt      <= '0;
                    if (bad_req(load_type_e'(funct3), addr[OFF_W-1:0])) begin
                        err    <= 1'b1;
                        result <= '0;
                        state  <= DONE;
                    end else begin
                        state  <= WAIT;
                    end
                end
                // Data arriving on the timeout cycle still wins.
                WAIT: if (mem_rvalid) begin
                    result <= ext;
                    err    <= 1'b0;
                    state  <= DONE;
                end else if (cnt == CW'(TIMEOUT)) begin
                    result <= '0;
                    err    <= 1'b1;
                    state  <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
